cache_refill_engine: RTL and testbench
======================================

Name: cache_refill_engine

Overview:
- Miss handler sitting directly downstream of direct_mapped_cache, between the cache and the backing byte-wide main memory.
- On a cache miss it optionally writes back the dirty victim line, then fetches the missing block byte by byte and streams it into the cache line.
- Signals completion so the cache can replay the access.
- Keeps saturating fill and write-back counters for hit/miss metric reporting.

Parameters:
BLOCK_SIZE, 16, bytes per cache line; power of two, 2..256
OFFSET_W, $clog2(BLOCK_SIZE), derived localparam; byte-offset width
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  cache requests a refill
req_ready  out  1  engine idle, can accept a request
req_addr  in  32  missing address; offset bits ignored
wb_en  in  1  victim line is dirty; sampled with the request
wb_addr  in  32  victim block address; offset bits ignored
line_rd_idx  out  OFFSET_W  byte index into victim line during write-back
line_rd_data  in  8  victim byte at line_rd_idx; combinational from cache
fill_we  out  1  write enable into cache line
fill_idx  out  OFFSET_W  byte index being filled
fill_data  out  8  fill byte
done  out  1  one-cycle pulse: line filled
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  32  memory byte address
mem_wdata  out  8  write data
mem_ack  in  1  memory completes the current request; may be the same cycle as mem_req
mem_rdata  in  8  read data, valid with mem_ack
fill_count  out  CNT_W  completed refills, saturating
wb_count  out  CNT_W  completed write-backs, saturating

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE; byte counter 0; latched addresses 0.
  - req_ready=1; done=0; mem_req=0; fill_we=0; fill_count=0; wb_count=0.
  - Reset asserted mid-transfer aborts immediately; mem_req drops without waiting for ack; no done pulse.
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - req_ready=1.
  - Handshake occurs when req_valid && req_ready at a rising edge.
  - On handshake, latch {req_addr[31:OFFSET_W], 0} and {wb_addr[31:OFFSET_W], 0}; clear the byte counter.
  - Go to WB if wb_en=1, else FILL.
  - req_ready=0 in all other states; req_valid is ignored outside IDLE.
- WB:
  - mem_req=1, mem_we=1, mem_addr=wb_base+cnt, line_rd_idx=cnt, mem_wdata=line_rd_data (combinational).
  - On mem_ack: cnt++.
  - At cnt==BLOCK_SIZE-1 with ack: cnt wraps to 0, wb_count++ (saturating at all-ones), go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr=fill_base+cnt.
  - fill_we=mem_ack, fill_idx=cnt, fill_data=mem_rdata; all combinational, same cycle as ack.
  - On ack: cnt++.
  - At cnt==BLOCK_SIZE-1 with ack: cnt wraps to 0, fill_count++ (saturating), go to DONE.
- DONE: done=1 for exactly one cycle, mem_req=0, then IDLE.
- mem_ack while mem_req=0 is ignored. mem_req stays high and the address stays stable until ack.
- line_rd_idx outside WB equals cnt and is a don't-care. mem_wdata outside WB is a don't-care. fill_we=0 outside FILL.
- Latency with zero-wait memory (ack every cycle), measured from the handshake edge to the done pulse:
  - no write-back: BLOCK_SIZE+1 cycles.
  - with write-back: 2*BLOCK_SIZE+1 cycles.
  - Each memory wait cycle adds one.
- Address arithmetic: base + cnt with no carry past the block, because the offset bits of base are zero.
- A new request can be accepted the cycle after done.

Test Plan:
1. Clean refill: reset, req_addr=0x0000_1004, wb_en=0, mem_ack tied 1, mem_rdata=low byte of mem_addr -> mem_addr 0x1000..0x100F in order; fill_we on 16 consecutive cycles with fill_idx 0..15 and fill_data 0x00..0x0F; done exactly 17 cycles after the handshake; fill_count=1, wb_count=0.
2. Dirty eviction: req_addr=0x2000, wb_en=1, wb_addr=0x1000, cache model returns 0xA0+idx -> 16 writes to 0x1000..0x100F with data 0xA0..0xAF, then 16 reads from 0x2000..0x200F; done at 33 cycles; wb_count=1, fill_count=2 cumulative.
3. Wait states: memory acks every third cycle -> mem_addr and mem_req stable between acks; no fill_we without ack; done after 16 acks (48+1 cycles).
4. Back-pressure/ignore: req_valid held high throughout -> second handshake only on the cycle after done; req_valid pulsed during FILL -> ignored; spurious mem_ack in IDLE -> no state change, no fill_we.
5. Reset mid-operation: assert reset after 5 fill bytes -> mem_req and fill_we fall asynchronously; after release req_ready=1, counters 0, no done; a new request refills from offset 0.
6. Saturation: force CNT_W=4, run 17 refills -> fill_count holds 15.

Source files
------------

// File: rtl/cache_refill_engine.sv
// Miss handler between a direct-mapped cache and byte-wide main memory.
// It writes back a dirty victim line when needed, then fills the missing block one byte at a time.
module cache_refill_engine #(
    parameter int  BLOCK_SIZE = 16,
    parameter int  CNT_W      = 16,
    localparam int OFFSET_W   = $clog2(BLOCK_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic                wb_en,
    input  logic [31:0]         wb_addr,
    output logic [OFFSET_W-1:0] line_rd_idx,
    input  logic [7:0]          line_rd_data,
    output logic                fill_we,
    output logic [OFFSET_W-1:0] fill_idx,
    output logic [7:0]          fill_data,
    output logic                done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic                mem_ack,
    input  logic [7:0]          mem_rdata,
    output logic [CNT_W-1:0]    fill_count,
    output logic [CNT_W-1:0]    wb_count
);
    localparam logic [OFFSET_W-1:0] LAST     = OFFSET_W'(BLOCK_SIZE - 1);
    localparam logic [31:0]         OFF_MASK = 32'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t              state, state_nx;
    logic [OFFSET_W-1:0] cnt;
    logic [31:0]         fill_base, wb_base;
    logic                last_beat;

    assign last_beat = mem_ack && (cnt == LAST);

    // Offset bits of both bases are zero, so OR-ing in cnt never carries out of the block.
    always_comb begin
        state_nx    = state;
        req_ready   = 1'b0;
        done        = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = fill_base | 32'(cnt);
        mem_wdata   = line_rd_data;
        line_rd_idx = cnt;
        fill_we     = 1'b0;
        fill_idx    = cnt;
        fill_data   = mem_rdata;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = wb_en ? WB : FILL;
            end
            WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = wb_base | 32'(cnt);
                if (last_beat) state_nx = FILL;
            end
            FILL: begin
                mem_req = 1'b1;
                fill_we = mem_ack;
                if (last_beat) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            fill_base  <= '0;
            wb_base    <= '0;
            fill_count <= '0;
            wb_count   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    fill_base <= req_addr & ~OFF_MASK;
                    wb_base   <= wb_addr & ~OFF_MASK;
                    cnt       <= '0;
                end
                WB: if (mem_ack) begin
                    cnt <= cnt + OFFSET_W'(1);
                    if (last_beat && (wb_count != '1)) wb_count <= wb_count + CNT_W'(1);
                end
                FILL: if (mem_ack) begin
                    cnt <= cnt + OFFSET_W'(1);
                    if (last_beat && (fill_count != '1)) fill_count <= fill_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_engine.sv
// Bench for cache_refill_engine: a transaction-level model of expected memory beats
// is checked against the DUT every cycle, alongside directed scenarios with literal expectations.
module tb_cache_refill_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, wb_en, mem_ack;
    logic [31:0] req_addr, wb_addr;
    logic        req_ready, fill_we, done, mem_req, mem_we;
    logic [3:0]  line_rd_idx, fill_idx;
    logic [7:0]  line_rd_data, fill_data, mem_wdata, mem_rdata;
    logic [31:0] mem_addr;
    logic [15:0] fill_count, wb_count;

    logic        s_req_ready, s_fill_we, s_done, s_mem_req, s_mem_we;
    logic [3:0]  s_line_rd_idx, s_fill_idx;
    logic [7:0]  s_fill_data, s_mem_wdata;
    logic [31:0] s_mem_addr;
    logic [3:0]  s_fill_count, s_wb_count;

    always #5 clk = ~clk;

    cache_refill_engine #(.BLOCK_SIZE(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .wb_en(wb_en), .wb_addr(wb_addr),
        .line_rd_idx(line_rd_idx), .line_rd_data(line_rd_data),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_count(fill_count), .wb_count(wb_count));

    cache_refill_engine #(.BLOCK_SIZE(16), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_addr(req_addr), .wb_en(wb_en), .wb_addr(wb_addr),
        .line_rd_idx(s_line_rd_idx), .line_rd_data(line_rd_data),
        .fill_we(s_fill_we), .fill_idx(s_fill_idx), .fill_data(s_fill_data), .done(s_done),
        .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_count(s_fill_count), .wb_count(s_wb_count));

    // Cache victim line and memory contents as simple functions of index/address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8];
    endfunction
    assign line_rd_data = 8'hA0 + {4'h0, line_rd_idx};
    assign mem_rdata    = mem_byte(mem_addr);

    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ack policy: mode 0 acks every cycle; mode 1 acks every third cycle after the handshake.
    int cyc = 0, hs_c = 0, ack_mode = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        mem_ack = (ack_mode == 0) ? 1'b1 : (((cyc - hs_c) % 3) == 0);
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        last;
    } beat_t;

    beat_t       q[$];
    beat_t       b;
    logic        m_idle = 1'b1, m_done = 1'b0, nx_idle, nx_done;
    logic [15:0] m_fill = '0, m_wb = '0;
    logic [31:0] fb, wbb;
    int          hs_cnt = 0, dn_cnt = 0, last_lat = 0, last_done_c = 0;
    int          fill_beats = 0, wr_beats = 0;
    logic [31:0] first_fill_addr, first_wr_addr;
    logic [7:0]  first_fill_data, first_wr_data, last_fill_data;

    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            m_idle = 1'b1; m_done = 1'b0; m_fill = '0; m_wb = '0;
        end else begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, m_idle});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("fill_count", {16'b0, fill_count}, {16'b0, m_fill});
            chk("wb_count", {16'b0, wb_count}, {16'b0, m_wb});
            chk("mem_req", {31'b0, mem_req}, {31'b0, (q.size() != 0)});
            if (done) begin
                dn_cnt++;
                last_lat    = cyc - hs_c;
                last_done_c = cyc;
            end
            nx_idle = m_idle;
            nx_done = 1'b0;
            if (q.size() != 0 && mem_req) begin
                b = q[0];
                chk("mem_we", {31'b0, mem_we}, {31'b0, b.we});
                chk("mem_addr", mem_addr, b.addr);
                if (b.we) chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, b.data});
                if (mem_ack) begin
                    void'(q.pop_front());
                    if (b.we) begin
                        chk("fill_we_wb", {31'b0, fill_we}, 32'd0);
                        if (wr_beats == 0) begin
                            first_wr_addr = mem_addr;
                            first_wr_data = mem_wdata;
                        end
                        wr_beats++;
                        if (b.last && m_wb != 16'hFFFF) m_wb = m_wb + 16'd1;
                    end else begin
                        chk("fill_we", {31'b0, fill_we}, 32'd1);
                        chk("fill_idx", {28'b0, fill_idx}, {28'b0, b.addr[3:0]});
                        chk("fill_data", {24'b0, fill_data}, {24'b0, b.data});
                        if (fill_beats == 0) begin
                            first_fill_addr = mem_addr;
                            first_fill_data = fill_data;
                        end
                        last_fill_data = fill_data;
                        fill_beats++;
                        if (b.last) begin
                            if (m_fill != 16'hFFFF) m_fill = m_fill + 16'd1;
                            nx_done = 1'b1;
                        end
                    end
                end else begin
                    chk("fill_we_wait", {31'b0, fill_we}, 32'd0);
                end
            end else begin
                chk("fill_we_idle", {31'b0, fill_we}, 32'd0);
            end
            if (m_idle && req_valid) begin
                fb  = {req_addr[31:4], 4'h0};
                wbb = {wb_addr[31:4], 4'h0};
                if (wb_en)
                    for (int i = 0; i < 16; i++) begin
                        b = '{1'b1, wbb + 32'(i), 8'hA0 + 8'(i), (i == 15)};
                        q.push_back(b);
                    end
                for (int i = 0; i < 16; i++) begin
                    b = '{1'b0, fb + 32'(i), mem_byte(fb + 32'(i)), (i == 15)};
                    q.push_back(b);
                end
                nx_idle    = 1'b0;
                hs_cnt++;
                hs_c       = cyc;
                fill_beats = 0;
                wr_beats   = 0;
            end
            if (m_done) nx_idle = 1'b1;
            m_idle = nx_idle;
            m_done = nx_done;
        end
    end

    task automatic wait_hs(input int h0);
        int k = 0;
        while (hs_cnt == h0 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("handshake", 32'(hs_cnt - h0), 32'd1);
    endtask

    task automatic send(input logic [31:0] a, input logic w, input logic [31:0] wa);
        int h0;
        @(posedge clk); #2;
        req_addr = a; wb_en = w; wb_addr = wa; req_valid = 1'b1;
        h0 = hs_cnt;
        wait_hs(h0);
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = dn_cnt;
        int k  = 0;
        while (dn_cnt == d0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_seen", 32'(dn_cnt - d0), 32'd1);
    endtask

    initial begin
        int h, dc, k;
        reset = 1'b0; req_valid = 1'b0; wb_en = 1'b0;
        req_addr = '0; wb_addr = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_fill_we", {31'b0, fill_we}, 32'd0);
        chk("rst_fill_count", {16'b0, fill_count}, 32'd0);
        chk("rst_wb_count", {16'b0, wb_count}, 32'd0);
        @(negedge clk); #2;
        reset = 1'b1;

        // Clean refill, offset bits of the request ignored; ack is high in IDLE too.
        send(32'h0000_1004, 1'b0, 32'hDEAD_BEEF);
        wait_done(100);
        chk("t1_latency", 32'(last_lat), 32'd17);
        chk("t1_first_addr", first_fill_addr, 32'h0000_1000);
        chk("t1_first_data", {24'b0, first_fill_data}, 32'h10);
        chk("t1_last_data", {24'b0, last_fill_data}, 32'h1F);
        chk("t1_fill_count", {16'b0, fill_count}, 32'd1);
        chk("t1_wb_count", {16'b0, wb_count}, 32'd0);

        // Dirty eviction.
        send(32'h0000_2000, 1'b1, 32'h0000_100C);
        wait_done(100);
        chk("t2_latency", 32'(last_lat), 32'd33);
        chk("t2_first_wr_addr", first_wr_addr, 32'h0000_1000);
        chk("t2_first_wr_data", {24'b0, first_wr_data}, 32'hA0);
        chk("t2_wr_beats", 32'(wr_beats), 32'd16);
        chk("t2_first_fill_data", {24'b0, first_fill_data}, 32'h20);
        chk("t2_wb_count", {16'b0, wb_count}, 32'd1);
        chk("t2_fill_count", {16'b0, fill_count}, 32'd2);

        // Wait states: one ack every third cycle.
        ack_mode = 1;
        send(32'h0000_4010, 1'b0, 32'h0);
        wait_done(200);
        chk("t3_latency", 32'(last_lat), 32'd49);
        ack_mode = 0;

        // req_valid held high: next handshake must be the cycle right after done.
        @(posedge clk); #2;
        req_addr = 32'h0000_5000; wb_en = 1'b0; req_valid = 1'b1;
        h = hs_cnt;
        wait_hs(h);
        @(posedge clk); #2;
        req_addr = 32'h0000_5010;
        wait_done(100);
        dc = last_done_c;
        h = hs_cnt;
        wait_hs(h);
        chk("t4_b2b_gap", 32'(hs_c - dc), 32'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        h = hs_cnt;
        req_addr = 32'h0000_7000; req_valid = 1'b1;
        @(posedge clk); #2;
        req_valid = 1'b0;
        wait_done(100);
        chk("t4_ignored_valid", 32'(hs_cnt - h), 32'd0);
        chk("t4_fill_count", {16'b0, fill_count}, 32'd5);

        // Reset asserted after five fill bytes.
        send(32'h0000_3004, 1'b0, 32'h0);
        k = 0;
        while (fill_beats < 5 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        chk("t5_beats_before_rst", 32'(fill_beats), 32'd5);
        @(posedge clk); #3;
        chk("t5_pre_mem_req", {31'b0, mem_req}, 32'd1);
        chk("t5_pre_fill_we", {31'b0, fill_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_mem_req", {31'b0, mem_req}, 32'd0);
        chk("t5_fill_we", {31'b0, fill_we}, 32'd0);
        chk("t5_done", {31'b0, done}, 32'd0);
        chk("t5_req_ready", {31'b0, req_ready}, 32'd1);
        chk("t5_fill_count", {16'b0, fill_count}, 32'd0);
        chk("t5_s_fill_count", {28'b0, s_fill_count}, 32'd0);
        @(negedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        send(32'h0000_3008, 1'b0, 32'h0);
        wait_done(100);
        chk("t5_latency", 32'(last_lat), 32'd17);
        chk("t5_first_addr", first_fill_addr, 32'h0000_3000);
        chk("t5_refill_count", {16'b0, fill_count}, 32'd1);

        // Saturation on the narrow-counter instance.
        for (int i = 0; i < 17; i++) begin
            send(32'h0001_0000 + 32'(i * 16), (i % 4) == 0, 32'h0002_0000 + 32'(i * 16));
            wait_done(100);
        end
        chk("t6_fill_count", {16'b0, fill_count}, 32'd18);
        chk("t6_wb_count", {16'b0, wb_count}, 32'd5);
        chk("t6_s_fill_count_sat", {28'b0, s_fill_count}, 32'd15);
        chk("t6_s_wb_count", {28'b0, s_wb_count}, 32'd5);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
